// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit: FSM states, access
// size encodings, word geometry and small lane helpers.
package mem_pkg;

  localparam int REG_SIZE        = 32;
  localparam int ADDRESS_SPACE_W = 256;
  localparam int WORD_BYTES      = REG_SIZE / 8;
  localparam int LANE_W          = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    MERGE_WR,
    RESP
  } mem_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  // Right-aligned data mask for an access size; unknown encodings act as word.
  function automatic logic [REG_SIZE-1:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = {{(REG_SIZE-8){1'b0}}, 8'hFF};
      SIZE_HALF: size_mask = {{(REG_SIZE-16){1'b0}}, 16'hFFFF};
      default:   size_mask = '1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [LANE_W-1:0] lane);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lane[0];
      default:   misaligned = (lane != '0);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response channels plus the single-port memory bus.
// master = core and memory side, slave = the access unit.
interface mem_access_unit_if;

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [1:0]                   req_size;
  logic [mem_pkg::REG_SIZE-1:0] req_addr;
  logic [mem_pkg::REG_SIZE-1:0] req_wdata;

  logic                         resp_valid;
  logic                         resp_ready;
  logic [mem_pkg::REG_SIZE-1:0] resp_rdata;
  logic                         resp_err;

  logic                         mem_EN;
  logic                         mem_RW;
  logic [mem_pkg::REG_SIZE-1:0] mem_addr;
  logic [mem_pkg::REG_SIZE-1:0] mem_wdata;
  logic [mem_pkg::REG_SIZE-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_EN, mem_RW, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_EN, mem_RW, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane extract (zero-extended) and read-modify-write merge.
// Present only when SUBWORD_ACCESS_EN is defined.
`ifdef SUBWORD_ACCESS_EN
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [REG_SIZE-1:0] word,
  input  logic [1:0]          size,
  input  logic [LANE_W-1:0]   lane,
  input  logic [REG_SIZE-1:0] wdata,
  output logic [REG_SIZE-1:0] extracted,
  output logic [REG_SIZE-1:0] merged
);

  logic [REG_SIZE-1:0] mask;
  logic [LANE_W+2:0]   shift;

  assign shift     = {lane, 3'b000};
  assign mask      = size_mask(size);
  assign extracted = (word >> shift) & mask;
  assign merged    = (word & ~(mask << shift)) | ((wdata & mask) << shift);

endmodule
`endif

// File: rtl/mem_access_unit.sv
// Initiator for a single-port synchronous memory: one load/store at a time,
// sub-word read-modify-write when SUBWORD_ACCESS_EN is defined.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_LIMIT = ADDRESS_SPACE_W
) (
  input logic           clk,
  input logic           rst,
  mem_access_unit_if.slave bus
);

  mem_state_t          state;
  logic                lat_write;
  logic                lat_full;
  logic [1:0]          lat_size;
  logic [LANE_W-1:0]   lat_lane;
  logic [REG_SIZE-1:0] lat_addr;
  logic [REG_SIZE-1:0] lat_wdata;

  logic                mem_en_q;
  logic                mem_rw_q;
  logic [REG_SIZE-1:0] mem_addr_q;
  logic [REG_SIZE-1:0] mem_wdata_q;

  logic                resp_valid_q;
  logic                resp_err_q;
  logic [REG_SIZE-1:0] resp_rdata_q;

  logic [REG_SIZE-1:0] word_idx;
  logic [LANE_W-1:0]   lane;
  logic                full_word;
  logic                req_err;
  logic [REG_SIZE-1:0] load_data;
  logic [REG_SIZE-1:0] merged_word;

`ifdef SUBWORD_ACCESS_EN
  assign word_idx  = bus.req_addr >> LANE_W;
  assign lane      = bus.req_addr[LANE_W-1:0];
  assign full_word = (bus.req_size != SIZE_BYTE) && (bus.req_size != SIZE_HALF);
  assign req_err   = (word_idx >= REG_SIZE'(ADDR_LIMIT)) || misaligned(bus.req_size, lane);

  mem_lane_align u_lane_align (
    .word      (bus.mem_rdata),
    .size      (lat_size),
    .lane      (lat_lane),
    .wdata     (lat_wdata),
    .extracted (load_data),
    .merged    (merged_word)
  );
`else
  assign word_idx    = bus.req_addr;
  assign lane        = '0;
  assign full_word   = 1'b1;
  assign req_err     = (word_idx >= REG_SIZE'(ADDR_LIMIT));
  assign load_data   = bus.mem_rdata;
  assign merged_word = lat_wdata;

  logic unused_size;
  assign unused_size = ^{bus.req_size, lat_size, lat_lane};
`endif

  // NOTE: reset is applied combinationally to mem_EN so a reset landing in an
  // access cycle never reaches the memory; the registered enable clears one edge later.
  assign bus.mem_EN     = mem_en_q & ~rst;
  assign bus.mem_RW     = mem_rw_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.req_ready  = (state == IDLE) & ~rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // NOTE: all state uses non-blocking assignments so every branch sees the
  // pre-edge values and the whole FSM updates atomically at the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_write    <= 1'b0;
      lat_full     <= 1'b0;
      lat_size     <= '0;
      lat_lane     <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write <= bus.req_write;
            lat_full  <= full_word;
            lat_size  <= bus.req_size;
            lat_lane  <= lane;
            lat_addr  <= word_idx;
            lat_wdata <= bus.req_wdata;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state        <= RESP;
            end else begin
              mem_en_q    <= 1'b1;
              mem_addr_q  <= word_idx;
              mem_rw_q    <= bus.req_write && full_word;
              mem_wdata_q <= (bus.req_write && full_word) ? bus.req_wdata : '0;
              state       <= ACCESS;
            end
          end
        end

        ACCESS: begin
          mem_en_q    <= 1'b0;
          mem_rw_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          if (lat_write && lat_full) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            state        <= RESP;
          end else begin
            state <= WAIT;
          end
        end

        // mem_rdata now holds the word read in ACCESS.
        WAIT: begin
          if (lat_write) begin
            mem_en_q    <= 1'b1;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= lat_addr;
            mem_wdata_q <= merged_word;
            state       <= MERGE_WR;
          end else begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_data;
            state        <= RESP;
          end
        end

        MERGE_WR: begin
          mem_en_q     <= 1'b0;
          mem_rw_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state        <= RESP;
        end

        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an attached synchronous memory model;
// sub-word scenarios run when SUBWORD_ACCESS_EN is defined.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   en_count = 0;

  logic [31:0] mem_model [0:255];

  mem_access_unit_if bus ();

  mem_access_unit #(.ADDR_LIMIT(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory: access at the enabled edge, registered read data that holds otherwise.
  always @(posedge clk) begin
    if (bus.mem_EN) begin
      en_count <= en_count + 1;
      if (bus.mem_addr < 32'd256) begin
        if (bus.mem_RW) mem_model[bus.mem_addr[7:0]] <= bus.mem_wdata;
        else            bus.mem_rdata <= mem_model[bus.mem_addr[7:0]];
      end
    end
  end

  function automatic logic [31:0] waddr(input int idx);
`ifdef SUBWORD_ACCESS_EN
    waddr = 32'(idx) << 2;
`else
    waddr = 32'(idx);
`endif
  endfunction

  // Issue one request with resp_ready=1; lat is the cycle resp_valid is seen (-1 on timeout).
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = sz;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1;
    rd  = 32'hFFFF_FFFF;
    er  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c;
        rd  = bus.resp_rdata;
        er  = bus.resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", bus.resp_rdata); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
    checks++; if (bus.mem_EN !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", bus.mem_EN); end
    checks++; if ({bus.mem_RW, bus.mem_addr, bus.mem_wdata} !== 65'h0) begin errors++; $display("FAIL reset_mem_bus: got %b/%h/%h expected zeros", bus.mem_RW, bus.mem_addr, bus.mem_wdata); end
  endtask

  task automatic test_word_store_load();
    int lat; logic [31:0] rd; logic er; int en0;
    en0 = en_count;
    run_req(1'b1, 2'd2, waddr(5), 32'hDEAD_BEEF, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency: got %0d expected 2", lat); end
    checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL store_resp: got err=%b data=%h expected err=0 data=0", er, rd); end
    checks++; if (en_count - en0 !== 1) begin errors++; $display("FAIL store_mem_en_cycles: got %0d expected 1", en_count - en0); end
    checks++; if (mem_model[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_mem_word: got %h expected deadbeef", mem_model[5]); end
    en0 = en_count;
    run_req(1'b0, 2'd2, waddr(5), 32'h0, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", er); end
    checks++; if (en_count - en0 !== 1) begin errors++; $display("FAIL load_mem_en_cycles: got %0d expected 1", en_count - en0); end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic er; int en0;
    en0 = en_count;
    run_req(1'b0, 2'd2, waddr(256), 32'h0, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL range_err_latency: got %0d expected 1", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err_flag: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_err_data: got %h expected 0", rd); end
    checks++; if (en_count !== en0) begin errors++; $display("FAIL range_err_mem_en: got %0d enables expected 0", en_count - en0); end
    run_req(1'b1, 2'd2, waddr(255), 32'h1234_5678, lat, rd, er);
    checks++; if (lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL top_store: got lat=%0d err=%b expected lat=2 err=0", lat, er); end
    run_req(1'b0, 2'd2, waddr(255), 32'h0, lat, rd, er);
    checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL top_load: got lat=%0d err=%b expected lat=3 err=0", lat, er); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL top_load_data: got %h expected 12345678", rd); end
  endtask

  task automatic test_backpressure();
    int en0; int lat;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_addr = waddr(5);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int w = 0; w < 20 && !bus.resp_valid; w++) @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_timeout: got resp_valid=%b expected 1", bus.resp_valid); end
    // A second request waits while the response is held.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = waddr(9); bus.req_wdata = 32'hCAFE_F00D;
    en0 = en_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus.resp_valid); end
      checks++; if (bus.resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h expected deadbeef", i, bus.resp_rdata); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, bus.req_ready); end
    end
    checks++; if (en_count !== en0) begin errors++; $display("FAIL bp_mem_idle: got %0d enables expected 0", en_count - en0); end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", bus.resp_valid, bus.req_ready); end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin lat = c; break; end
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL bp_pending_store_latency: got %0d expected 2", lat); end
    @(posedge clk);
    #1;
    checks++; if (mem_model[9] !== 32'hCAFE_F00D) begin errors++; $display("FAIL bp_pending_store_data: got %h expected cafef00d", mem_model[9]); end
  endtask

  task automatic test_reset_in_access();
    int lat; logic [31:0] rd; logic er; int en0; logic seen;
    run_req(1'b1, 2'd2, waddr(7), 32'h1357_9BDF, lat, rd, er);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
    bus.req_addr = waddr(7); bus.req_wdata = 32'h0BAD_F00D;
    en0 = en_count;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_EN !== 1'b0) begin errors++; $display("FAIL rst_access_mem_en: got %b expected 0", bus.mem_EN); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_access_state: got valid=%b ready=%b expected 0/1", bus.resp_valid, bus.req_ready); end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_access_no_resp: got %b expected 0", seen); end
    checks++; if (en_count !== en0) begin errors++; $display("FAIL rst_access_mem_en_count: got %0d expected 0", en_count - en0); end
    checks++; if (mem_model[7] !== 32'h1357_9BDF) begin errors++; $display("FAIL rst_access_mem_word: got %h expected 13579bdf", mem_model[7]); end
    run_req(1'b0, 2'd2, waddr(7), 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h1357_9BDF || lat !== 3) begin errors++; $display("FAIL rst_access_reload: got %h lat=%0d expected 13579bdf lat=3", rd, lat); end
  endtask

`ifdef SUBWORD_ACCESS_EN
  task automatic test_subword();
    int lat; logic [31:0] rd; logic er; int en0;
    run_req(1'b1, 2'd2, 32'd0, 32'h1122_3344, lat, rd, er);
    checks++; if (mem_model[0] !== 32'h1122_3344) begin errors++; $display("FAIL sw_init: got %h expected 11223344", mem_model[0]); end
    run_req(1'b1, 2'd0, 32'd1, 32'h0000_00AA, lat, rd, er);
    checks++; if (lat !== 4 || er !== 1'b0) begin errors++; $display("FAIL sw_byte_store: got lat=%0d err=%b expected lat=4 err=0", lat, er); end
    checks++; if (mem_model[0] !== 32'h1122_AA44) begin errors++; $display("FAIL sw_byte_merge: got %h expected 1122aa44", mem_model[0]); end
    run_req(1'b0, 2'd0, 32'd1, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000_00AA || lat !== 3) begin errors++; $display("FAIL sw_byte_load: got %h lat=%0d expected 000000aa lat=3", rd, lat); end
    run_req(1'b1, 2'd1, 32'd2, 32'h0000_BEEF, lat, rd, er);
    checks++; if (mem_model[0] !== 32'hBEEF_AA44) begin errors++; $display("FAIL sw_half_merge: got %h expected beefaa44", mem_model[0]); end
    run_req(1'b0, 2'd1, 32'd2, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL sw_half_load: got %h expected 0000beef", rd); end
    en0 = en_count;
    run_req(1'b0, 2'd1, 32'd3, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL sw_half_misaligned: got err=%b lat=%0d expected err=1 lat=1", er, lat); end
    run_req(1'b0, 2'd2, 32'd2, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL sw_word_misaligned: got %b expected 1", er); end
    checks++; if (en_count !== en0) begin errors++; $display("FAIL sw_misaligned_mem_en: got %0d expected 0", en_count - en0); end
  endtask
`else
  task automatic test_size_ignored();
    int lat; logic [31:0] rd; logic er;
    run_req(1'b1, 2'd0, 32'd12, 32'hA5A5_5A5A, lat, rd, er);
    checks++; if (lat !== 2 || mem_model[12] !== 32'hA5A5_5A5A) begin errors++; $display("FAIL nosw_store: got lat=%0d mem=%h expected lat=2 mem=a5a55a5a", lat, mem_model[12]); end
    run_req(1'b0, 2'd0, 32'd12, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hA5A5_5A5A || lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL nosw_load: got %h lat=%0d err=%b expected a5a55a5a lat=3 err=0", rd, lat, er); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd2;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_word_store_load();
    test_range();
    test_backpressure();
    test_reset_in_access();
`ifdef SUBWORD_ACCESS_EN
    test_subword();
`else
    test_size_ignored();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
